radix4_booth_seq_mult: RTL and testbench

- Iterative radix-4 Booth multiplier; the stage directly downstream of the Booth partial-product generator.
- Retires one Booth digit per cycle: scans a 3-bit multiplier window, forms the partial product (0, ±A, ±2A), shifts it by 2 bits per digit and accumulates it into a double-width product register.
- Sits in the posit FMAU mantissa datapath, in front of normalisation/rounding.
- Uses valid/ready handshakes on both sides and holds one transaction at a time.

---
 rtl/radix4_booth_seq_mult.sv | 110 +++++++++++
 tb/tb_radix4_booth_seq_mult.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix4_booth_seq_mult.sv
// Iterative radix-4 Booth multiplier: one digit per cycle, latency WIDTH/2 (signed) or WIDTH/2+1 (unsigned).
// One transaction in flight; in_ready only in IDLE, product held in DONE until out_ready.
module radix4_booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);
    localparam int E  = WIDTH + 2;
    localparam int AW = 2*WIDTH + 2;
    localparam int CW = $clog2(WIDTH/2 + 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] a_sh;
    logic [AW-1:0] a_neg;
    logic [AW-1:0] pp;
    logic [AW-1:0] acc;
    logic [E:0]    b_sh;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last_cnt;
    logic          sgn;
    logic          accept;
    logic          last_digit;
    logic          unused_acc_hi;

    assign accept     = in_valid && in_ready;
    // Signed operands need no digit for the redundant sign-extension bits.
    assign last_cnt   = sgn ? CW'(WIDTH/2 - 1) : CW'(WIDTH/2);
    assign last_digit = (cnt == last_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (last_digit) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // a_sh already carries the 2i weight, so partial products need no variable shift.
    assign a_neg = ~a_sh + AW'(1);

    always_comb begin
        pp = '0;
        case (b_sh[2:0])
            3'b001, 3'b010: pp = a_sh;
            3'b011:         pp = {a_sh[AW-2:0], 1'b0};
            3'b100:         pp = {a_neg[AW-2:0], 1'b0};
            3'b101, 3'b110: pp = a_neg;
            default:        pp = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
            sgn  <= 1'b0;
        end else if (accept) begin
            sgn  <= in_signed;
            a_sh <= {{(AW-WIDTH){in_signed & in_a[WIDTH-1]}}, in_a};
            b_sh <= {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
            acc  <= '0;
            cnt  <= '0;
        end else if (state == BUSY) begin
            acc  <= acc + pp;
            a_sh <= {a_sh[AW-3:0], 2'b00};
            b_sh <= {2'b00, b_sh[E:2]};
            cnt  <= cnt + CW'(1);
        end
    end

    assign out_product   = acc[2*WIDTH-1:0];
    assign unused_acc_hi = ^acc[AW-1:2*WIDTH];

endmodule

// File: tb/tb_radix4_booth_seq_mult.sv
// Directed and randomised checks of radix4_booth_seq_mult at WIDTH=8 and WIDTH=16.
module tb_radix4_booth_seq_mult;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v8, r8, s8, ov8, or8, bz8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        v16, r16, s16, ov16, or16, bz16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int n_cmp = 0;
    int n_bad = 0;

    radix4_booth_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_signed(s8),
        .in_a(a8), .in_b(b8), .out_valid(ov8), .out_ready(or8),
        .out_product(p8), .busy(bz8)
    );

    radix4_booth_seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .in_signed(s16),
        .in_a(a16), .in_b(b16), .out_valid(ov16), .out_ready(or16),
        .out_product(p16), .busy(bz16)
    );

    function automatic logic [31:0] golden(input int w, input bit s,
                                           input logic [15:0] a, input logic [15:0] b);
        longint ae, be, pr;
        if (w == 8) begin
            ae = s ? longint'($signed(a[7:0])) : longint'(a[7:0]);
            be = s ? longint'($signed(b[7:0])) : longint'(b[7:0]);
        end else begin
            ae = s ? longint'($signed(a)) : longint'(a);
            be = s ? longint'($signed(b)) : longint'(b);
        end
        pr = ae * be;
        return (w == 8) ? {16'h0000, pr[15:0]} : pr[31:0];
    endfunction

    // Waits for IDLE, issues one operand pair, returns once out_valid is seen (or bound expires).
    task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b, input bit rdy,
                        output logic [15:0] p, output int lat, output int bcnt);
        int g;
        g = 0;
        while (!r8 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        s8 = s; a8 = a; b8 = b; v8 = 1'b1; or8 = rdy;
        @(posedge clk); #1;
        v8 = 1'b0; a8 = ~a; b8 = ~b; s8 = ~s;
        lat = 0; bcnt = 0;
        while (!ov8 && lat < 50) begin
            if (bz8) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        p = p8;
    endtask

    task automatic finish8();
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v8 = 0; s8 = 0; a8 = 0; b8 = 0; or8 = 0;
        v16 = 0; s16 = 0; a16 = 0; b16 = 0; or16 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if ({r8, ov8, bz8, p8} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL reset8: rdy/vld/busy/prod = %b%b%b %h, want 100 0000", r8, ov8, bz8, p8);
        end
        n_cmp++;
        if ({r16, ov16, bz16, p16} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset16: rdy/vld/busy/prod = %b%b%b %h, want 100 0", r16, ov16, bz16, p16);
        end
    endtask

    task automatic test_signed_basic();
        logic [15:0] p; int lat, bc;
        run8(1'b1, 8'h03, 8'hFB, 1'b1, p, lat, bc);
        n_cmp++;
        if (p !== 16'hFFF1) begin n_bad++; $display("FAIL s3xm5 product: got %h want fff1", p); end
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL s3xm5 latency: got %0d want 4", lat); end
        n_cmp++;
        if (bc !== 4) begin n_bad++; $display("FAIL s3xm5 busy cycles: got %0d want 4", bc); end
        @(posedge clk); #1;
        or8 = 1'b0;
        n_cmp++;
        if ({ov8, r8, bz8} !== 3'b010) begin
            n_bad++;
            $display("FAIL s3xm5 post-handshake vld/rdy/busy: got %b%b%b want 010", ov8, r8, bz8);
        end
    endtask

    task automatic test_signed_extremes();
        logic [15:0] p; int lat, bc;
        run8(1'b1, 8'h80, 8'h80, 1'b1, p, lat, bc);
        n_cmp++;
        if (p !== 16'h4000) begin n_bad++; $display("FAIL m128sq product: got %h want 4000", p); end
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL m128sq latency: got %0d want 4", lat); end
        run8(1'b1, 8'h80, 8'h7F, 1'b1, p, lat, bc);
        n_cmp++;
        if (p !== 16'hC080) begin n_bad++; $display("FAIL m128x127 product: got %h want c080", p); end
        finish8();
    endtask

    task automatic test_unsigned();
        logic [15:0] p; int lat, bc;
        run8(1'b0, 8'hFF, 8'hFF, 1'b1, p, lat, bc);
        n_cmp++;
        if (p !== 16'hFE01) begin n_bad++; $display("FAIL u255sq product: got %h want fe01", p); end
        n_cmp++;
        if (lat !== 5) begin n_bad++; $display("FAIL u255sq latency: got %0d want 5", lat); end
        n_cmp++;
        if (bc !== 5) begin n_bad++; $display("FAIL u255sq busy cycles: got %0d want 5", bc); end
        run8(1'b0, 8'h80, 8'h02, 1'b1, p, lat, bc);
        n_cmp++;
        if (p !== 16'h0100) begin n_bad++; $display("FAIL u128x2 product: got %h want 0100", p); end
        run8(1'b0, 8'h00, 8'h5A, 1'b1, p, lat, bc);
        n_cmp++;
        if ({p, 8'(lat)} !== {16'h0000, 8'd5}) begin
            n_bad++; $display("FAIL uzero product/lat: got %h/%0d want 0000/5", p, lat);
        end
        run8(1'b1, 8'h00, 8'h81, 1'b1, p, lat, bc);
        n_cmp++;
        if ({p, 8'(lat)} !== {16'h0000, 8'd4}) begin
            n_bad++; $display("FAIL szero product/lat: got %h/%0d want 0000/4", p, lat);
        end
        finish8();
    endtask

    task automatic test_backpressure();
        logic [15:0] p; int lat, bc;
        run8(1'b1, 8'h07, 8'h06, 1'b0, p, lat, bc);
        n_cmp++;
        if ({p, 8'(lat)} !== {16'h002A, 8'd4}) begin
            n_bad++; $display("FAIL bp product/lat: got %h/%0d want 002a/4", p, lat);
        end
        for (int i = 0; i < 10; i++) begin
            v8 = 1'b1; a8 = 8'h11; b8 = 8'h22; s8 = 1'b0;
            @(posedge clk); #1;
            n_cmp++;
            if ({ov8, r8, p8} !== {1'b1, 1'b0, 16'h002A}) begin
                n_bad++;
                $display("FAIL bp hold cycle %0d: vld/rdy/prod %b%b %h want 10 002a", i, ov8, r8, p8);
            end
        end
        v8 = 1'b0;
        finish8();
        n_cmp++;
        if ({ov8, r8} !== 2'b01) begin
            n_bad++; $display("FAIL bp release: vld/rdy %b%b want 01", ov8, r8);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p; int lat, bc; bit seen;
        s8 = 1'b1; a8 = 8'h55; b8 = 8'h33; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({r8, ov8, bz8, p8} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL midreset: rdy/vld/busy/prod %b%b%b %h want 100 0000", r8, ov8, bz8, p8);
        end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ov8) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset ghost output: got 1 want 0"); end
        run8(1'b1, 8'h02, 8'h02, 1'b1, p, lat, bc);
        n_cmp++;
        if (p !== 16'h0004) begin n_bad++; $display("FAIL post-reset 2x2: got %h want 0004", p); end
        finish8();
    endtask

    task automatic test_back_to_back();
        logic [15:0] p; int lat, bc;
        logic        vs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0]  va [5] = '{8'hFF, 8'h10, 8'h7F, 8'hFE, 8'h81};
        logic [7:0]  vb [5] = '{8'hFF, 8'h10, 8'h7F, 8'h03, 8'h02};
        logic [15:0] vp [5] = '{16'h0001, 16'h0100, 16'h3F01, 16'h02FA, 16'hFF02};
        for (int i = 0; i < 5; i++) begin
            run8(vs[i], va[i], vb[i], 1'b1, p, lat, bc);
            n_cmp++;
            if (p !== vp[i] || lat !== (vs[i] ? 4 : 5)) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got %h/%0d want %h/%0d", i, p, lat, vp[i], vs[i] ? 4 : 5);
            end
        end
        finish8();
    endtask

    task automatic test_random8();
        logic [15:0] p; int lat, bc; bit s; logic [7:0] a, b; logic [31:0] g;
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            a = 8'($urandom); b = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run8(s, a, b, 1'b0, p, lat, bc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            g = golden(8, s, {8'h00, a}, {8'h00, b});
            n_cmp++;
            if (p8 !== g[15:0] || lat !== (s ? 4 : 5)) begin
                n_bad++;
                $display("FAIL rand8[%0d] s=%0d %h*%h: got %h/%0d want %h/%0d",
                         i, s, a, b, p8, lat, g[15:0], s ? 4 : 5);
            end
            finish8();
        end
    endtask

    task automatic test_random16();
        int lat, gw; bit s; logic [15:0] a, b; logic [31:0] g;
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            a = 16'($urandom); b = 16'($urandom);
            if (i == 0) begin s = 1'b1; a = 16'h8000; b = 16'h8000; end
            if (i == 1) begin s = 1'b0; a = 16'hFFFF; b = 16'hFFFF; end
            gw = 0;
            while (!r16 && gw < 100) begin @(posedge clk); #1; gw++; end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            s16 = s; a16 = a; b16 = b; v16 = 1'b1;
            @(posedge clk); #1;
            v16 = 1'b0; a16 = ~a; b16 = ~b;
            lat = 0;
            while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            g = golden(16, s, a, b);
            n_cmp++;
            if (p16 !== g || lat !== (s ? 8 : 9)) begin
                n_bad++;
                $display("FAIL rand16[%0d] s=%0d %h*%h: got %h/%0d want %h/%0d",
                         i, s, a, b, p16, lat, g, s ? 8 : 9);
            end
            or16 = 1'b1;
            @(posedge clk); #1;
            or16 = 1'b0;
            n_cmp++;
            if (ov16 !== 1'b0) begin
                n_bad++; $display("FAIL rand16[%0d] extra output: out_valid %b want 0", i, ov16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_signed_extremes();
        test_unsigned();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random8();
        test_random16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
